// File: rtl/div32.sv
// Sequential signed divider: non-restoring on magnitudes, one quotient bit per cycle, then a sign-fix step.
// Latency: WIDTH+1 edges from accept to done (1 edge when the divisor is zero).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Rz_lo,
    output logic [WIDTH-1:0] Rz_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   p;          // signed partial remainder
    logic [WIDTH-1:0] q;          // |Ra| shifting out, quotient shifting in
    logic [WIDTH-1:0] b_mag;
    logic             sign_a;
    logic             sign_b;
    logic             zero_flag;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] rb_mag;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
    assign a_mag  = Ra[WIDTH-1] ? -Ra : Ra;
    assign rb_mag = Rb[WIDTH-1] ? -Rb : Rb;
    assign busy   = (state != IDLE);

    always_comb begin
        p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
        p_step = p[WIDTH] ? (p_sh + {1'b0, b_mag}) : (p_sh - {1'b0, b_mag});
        q_step = {q[WIDTH-2:0], ~p_step[WIDTH]};
        r_mag  = p[WIDTH] ? (p[WIDTH-1:0] + b_mag) : p[WIDTH-1:0];
        q_fix  = (sign_a ^ sign_b) ? -q : q;
        r_fix  = sign_a ? -r_mag : r_mag;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (Rb == '0) ? FIX : RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            p           <= '0;
            q           <= '0;
            b_mag       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_flag   <= 1'b0;
            cnt         <= '0;
            done        <= 1'b0;
            Rz_lo       <= '0;
            Rz_hi       <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a      <= Ra[WIDTH-1];
                        sign_b      <= Rb[WIDTH-1];
                        q           <= a_mag;
                        b_mag       <= rb_mag;
                        p           <= '0;
                        cnt         <= CW'(WIDTH);
                        zero_flag   <= (Rb == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    p   <= p_step;
                    q   <= q_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_flag;
                    if (zero_flag) begin
                        // q still holds |Ra| untouched, so re-applying the sign returns Ra.
                        Rz_lo <= '1;
                        Rz_hi <= sign_a ? -q : q;
                    end else begin
                        Rz_lo <= q_fix;
                        Rz_hi <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32.sv
// Randomized and directed bench for div32 against an arithmetic reference model.
module tb_div32;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        busy;
    logic        done;
    logic [31:0] Rz_lo;
    logic [31:0] Rz_hi;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    div32 #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .Ra          (Ra),
        .Rb          (Rb),
        .busy        (busy),
        .done        (done),
        .Rz_lo       (Rz_lo),
        .Rz_hi       (Rz_hi),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Truncating signed division done in 64-bit so the -2^31 / -1 case wraps naturally.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z, output int lat);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0]; r = lr[31:0]; z = 1'b0; lat = 33;
        end
    endfunction

    // Called at a negedge; returns at the negedge one cycle after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        Ra = a; Rb = b; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        Ra = $urandom; Rb = $urandom;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // k = edges after accept when done is seen, -1 if clear was applied, 999 on timeout.
    task automatic wait_done(input int pulse_at, input int clear_at, output int k, output int busy_bad);
        busy_bad = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                k = i;
                return;
            end
            if (busy !== 1'b1) busy_bad++;
            if (i == pulse_at) begin
                start = 1'b1; Ra = 32'd50; Rb = 32'd5;
            end else if (i == pulse_at + 1) begin
                start = 1'b0; Ra = $urandom; Rb = $urandom;
            end
            if (i == clear_at) begin
                clear = 1'b1;
                @(posedge clock);
                @(negedge clock);
                clear = 1'b0;
                k = -1;
                return;
            end
        end
        k = 999;
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input int k, input int busy_bad);
        logic [31:0] eq, er;
        logic        ez;
        int          elat;
        model(a, b, eq, er, ez, elat);
        check({tag, "_lat"}, k, elat);
        check({tag, "_q"}, Rz_lo, eq);
        check({tag, "_r"}, Rz_hi, er);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        check({tag, "_busy_run"}, busy_bad, 0);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          k, bb;
        logic [31:0] q_seen;
        issue(a, b);
        wait_done(-1, -1, k, bb);
        check_result(tag, a, b, k, bb);
        q_seen = Rz_lo;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, Rz_lo, q_seen);
    endtask

    initial begin
        int k, bb, cnt;
        logic [31:0] a, b;
        clear = 1'b1; start = 1'b0; Ra = '0; Rb = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_lo", Rz_lo, 32'd0);
        check("rst_hi", Rz_hi, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        clear = 1'b0;

        do_div("d100_7", 32'd100, 32'd7);
        do_div("dm100_7", 32'hFFFF_FF9C, 32'd7);
        do_div("d100_m7", 32'd100, 32'hFFFF_FFF9);
        do_div("dm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        do_div("dzero", 32'h1234_5678, 32'd0);
        do_div("dovf", 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("dm1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_div("d5_9", 32'd5, 32'd9);
        do_div("dmin_2", 32'h8000_0000, 32'd2);
        do_div("dzero_neg", 32'h8000_0001, 32'd0);

        // start while busy is ignored; start in the done cycle is taken
        issue(32'd1000, 32'd10);
        wait_done(10, -1, k, bb);
        check_result("b2b_first", 32'd1000, 32'd10, k, bb);
        issue(32'd50, 32'd5);
        wait_done(-1, -1, k, bb);
        check_result("b2b_second", 32'd50, 32'd5, k, bb);
        @(posedge clock);
        @(negedge clock);

        // clear mid-run aborts and zeroes outputs
        issue(32'd1000, 32'd10);
        wait_done(-1, 10, k, bb);
        check("clr_path", k, -1);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_lo", Rz_lo, 32'd0);
        check("clr_hi", Rz_hi, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) cnt++;
        end
        check("clr_no_done", cnt, 0);
        do_div("after_clr", 32'd81, 32'd9);

        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'h8000_0000;
                4: b = {28'd0, b[3:0]};
                5: b = {{24{b[31]}}, b[7:0]};
                default: ;
            endcase
            do_div("rnd", a, b);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
